// File: rtl/vend_stock_ctrl_pkg.sv
// Shared constants for the vending-machine stock controller:
// command opcodes, response status codes and the controller state encoding.
package vend_stock_pkg;

    localparam logic [1:0] OP_READ    = 2'd0;
    localparam logic [1:0] OP_VEND    = 2'd1;
    localparam logic [1:0] OP_RESTOCK = 2'd2;
    localparam logic [1:0] OP_CLEAR   = 2'd3;

    localparam logic [1:0] ST_OK    = 2'd0;
    localparam logic [1:0] ST_EMPTY = 2'd1;
    localparam logic [1:0] ST_SAT   = 2'd2;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_CLR  = 3'd4;
    localparam logic [2:0] S_RSP  = 3'd5;

endpackage

// File: rtl/vend_stock_ctrl_if.sv
// Command/response port between the vend FSM (or service port) and the
// stock controller. The master issues commands; the slave is the controller.
interface vend_stock_ctrl_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_item;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_status;

    modport master (
        output req_valid, req_op, req_item, req_data,
        input  req_ready, rsp_valid, rsp_data, rsp_status
    );

    modport slave (
        input  req_valid, req_op, req_item, req_data,
        output req_ready, rsp_valid, rsp_data, rsp_status
    );
endinterface

// File: rtl/vend_stock_ctrl_alu.sv
// Combinational count update: decrement with empty detection for VEND and
// saturating add for RESTOCK. READ and CLEAR pass the count through.
module stock_alu
    import vend_stock_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] cnt,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] qty,
    output logic [DATA_W-1:0] next_cnt,
    output logic [1:0]        status
);

    localparam logic [DATA_W-1:0] MAX_CNT = '1;

    logic [DATA_W:0] sum;

    // Next count and status from the current count and the command; the sum
    // carries one extra bit so an overflowing restock can be clipped.
    always_comb begin
        sum      = {1'b0, cnt} + {1'b0, qty};
        next_cnt = cnt;
        status   = ST_OK;
        case (op)
            OP_VEND: begin
                if (cnt == '0) begin
                    next_cnt = '0;
                    status   = ST_EMPTY;
                end else begin
                    next_cnt = cnt - DATA_W'(1);
                end
            end
            OP_RESTOCK: begin
                if (sum[DATA_W]) begin
                    next_cnt = MAX_CNT;
                    status   = ST_SAT;
                end else begin
                    next_cnt = sum[DATA_W-1:0];
                end
            end
            default: begin
                next_cnt = cnt;
            end
        endcase
    end

endmodule

// File: rtl/vend_stock_ctrl.sv
// Stock controller: accepts one command at a time and sequences the
// read/modify/write cycles on the external single-port stock RAM, then
// returns a one-cycle response with the resulting count and status.
module vend_stock_ctrl
    import vend_stock_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    vend_stock_ctrl_if.slave  cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [2:0]        state;
    logic [2:0]        next_state;
    logic              ready_q;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] item_q;
    logic [DATA_W-1:0] qty_q;
    logic [DATA_W-1:0] cnt;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] rsp_data_q;
    logic [1:0]        rsp_status_q;

    logic              accept;
    logic [DATA_W-1:0] alu_cnt;
    logic [DATA_W-1:0] alu_next;
    logic [1:0]        alu_status;

    assign accept = (state == S_IDLE) && cmd.req_valid && ready_q;

    // In CAP the decision must use the RAM data that is only now arriving;
    // in WR the captured count is used because the RAM output has moved on.
    assign alu_cnt = (state == S_CAP) ? mem_rdata : cnt;

    stock_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .cnt      (alu_cnt),
        .op       (op_q),
        .qty      (qty_q),
        .next_cnt (alu_next),
        .status   (alu_status)
    );

    // Next-state decode for the command sequencer.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = (cmd.req_op == OP_CLEAR) ? S_CLR : S_RD;
                end
            end
            S_RD:  next_state = S_CAP;
            S_CAP: begin
                if ((op_q == OP_READ) || (op_q == OP_VEND && alu_status == ST_EMPTY)) begin
                    next_state = S_RSP;
                end else begin
                    next_state = S_WR;
                end
            end
            S_WR:  next_state = S_RSP;
            S_CLR: begin
                if (clr_addr == LAST_ADDR) begin
                    next_state = S_RSP;
                end
            end
            S_RSP:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State register; ready is registered so it stays low through reset and
    // rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state == S_IDLE);
        end
    end

    // Latch the command fields on accept so later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_READ;
            item_q <= '0;
            qty_q  <= '0;
        end else if (accept) begin
            op_q   <= cmd.req_op;
            item_q <= cmd.req_item;
            qty_q  <= cmd.req_data;
        end
    end

    // Capture the RAM read data and walk the clear address without wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            clr_addr <= '0;
        end else begin
            if (state == S_CAP) begin
                cnt <= mem_rdata;
            end
            if (accept) begin
                clr_addr <= '0;
            end else if (state == S_CLR && clr_addr != LAST_ADDR) begin
                clr_addr <= clr_addr + ADDR_W'(1);
            end
        end
    end

    // Load the response on entry to RSP and hold it until the next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
        end else if (next_state == S_RSP) begin
            if (state == S_CLR) begin
                rsp_data_q   <= '0;
                rsp_status_q <= ST_OK;
            end else begin
                rsp_data_q   <= alu_next;
                rsp_status_q <= alu_status;
            end
        end
    end

    // RAM bus decode straight from the state so reset drops the write at once.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            S_RD, S_CAP: mem_addr = item_q;
            S_WR: begin
                mem_addr  = item_q;
                mem_we    = 1'b1;
                mem_wdata = alu_next;
            end
            S_CLR: begin
                mem_addr = clr_addr;
                mem_we   = 1'b1;
            end
            default: mem_addr = '0;
        endcase
    end

    assign cmd.req_ready  = ready_q;
    assign cmd.rsp_valid  = (state == S_RSP);
    assign cmd.rsp_data   = rsp_data_q;
    assign cmd.rsp_status = rsp_status_q;

endmodule

// File: tb/tb_vend_stock_ctrl.sv
// Directed bench for vend_stock_ctrl with a behavioural sync-write /
// sync-read stock RAM (ADDR_W=2, DATA_W=4).
module tb_vend_stock_ctrl;
    import vend_stock_pkg::*;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [DATA_W-1:0] ram [0:3] = '{4'hA, 4'hA, 4'hA, 4'hA};

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] we_addr [0:7];
    logic [DATA_W-1:0] we_data [0:7];

    int          lat;
    int          we_count;
    int          ready_high;
    logic [3:0]  rdata;
    logic [1:0]  rstatus;
    int          accepts;
    int          acc_cycle [0:1];
    int          pulses;
    int          ready_low;
    int          guard;

    vend_stock_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cmd_if ();

    vend_stock_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd_if),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural stock RAM: write on the edge when enabled, read data one clock later.
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    // Hard stop in case something hangs outside the bounded loops.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Issue one command, then follow it up to the response cycle.
    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] item, input logic [3:0] qty,
                                 output int lat_o, output logic [3:0] data_o, output logic [1:0] status_o,
                                 output int we_o, output int ready_o);
        int g;
        g = 0;
        while (!cmd_if.req_ready && g < 20) begin
            tick();
            g++;
        end
        cmd_if.req_valid = 1'b1;
        cmd_if.req_op    = op;
        cmd_if.req_item  = item;
        cmd_if.req_data  = qty;
        tick();
        lat_o = 1;
        cmd_if.req_valid = 1'b0;
        cmd_if.req_op    = ~op;
        cmd_if.req_item  = ~item;
        cmd_if.req_data  = ~qty;
        we_o    = 0;
        ready_o = 0;
        while (!cmd_if.rsp_valid && lat_o < 30) begin
            if (mem_we && we_o < 8) begin
                we_addr[we_o] = mem_addr;
                we_data[we_o] = mem_wdata;
                we_o++;
            end
            if (cmd_if.req_ready) ready_o++;
            tick();
            lat_o++;
        end
        if (!cmd_if.rsp_valid) lat_o = -1;
        data_o   = cmd_if.rsp_data;
        status_o = cmd_if.rsp_status;
    endtask

    initial begin
        cmd_if.req_valid = 1'b0;
        cmd_if.req_op    = OP_READ;
        cmd_if.req_item  = '0;
        cmd_if.req_data  = '0;

        // Reset values
        #12;
        checkOutput("rst_ready",  32'(cmd_if.req_ready), 0);
        checkOutput("rst_rspv",   32'(cmd_if.rsp_valid), 0);
        checkOutput("rst_we",     32'(mem_we), 0);
        checkOutput("rst_addr",   32'(mem_addr), 0);
        checkOutput("rst_wdata",  32'(mem_wdata), 0);
        checkOutput("rst_rdata",  32'(cmd_if.rsp_data), 0);
        checkOutput("rst_status", 32'(cmd_if.rsp_status), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("ready_after_rst", 32'(cmd_if.req_ready), 1);

        // CLEAR: four consecutive zero writes, response after 5 clocks
        applyStimulus(OP_CLEAR, 2'd1, 4'd7, lat, rdata, rstatus, we_count, ready_high);
        checkOutput("clr_lat", 32'(lat), 5);
        checkOutput("clr_data", 32'(rdata), 0);
        checkOutput("clr_status", 32'(rstatus), ST_OK);
        checkOutput("clr_we_count", 32'(we_count), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("clr_we_addr", 32'(we_addr[i]), i);
            checkOutput("clr_we_data", 32'(we_data[i]), 0);
        end
        checkOutput("clr_ram", 32'({ram[0], ram[1], ram[2], ram[3]}), 0);
        checkOutput("clr_ready_low", 32'(ready_high), 0);

        // RESTOCK item 2 by 9
        applyStimulus(OP_RESTOCK, 2'd2, 4'd9, lat, rdata, rstatus, we_count, ready_high);
        checkOutput("rs1_lat", 32'(lat), 4);
        checkOutput("rs1_data", 32'(rdata), 9);
        checkOutput("rs1_status", 32'(rstatus), ST_OK);
        checkOutput("rs1_we_count", 32'(we_count), 1);
        checkOutput("rs1_ram2", 32'(ram[2]), 9);

        // READ item 2
        applyStimulus(OP_READ, 2'd2, 4'd0, lat, rdata, rstatus, we_count, ready_high);
        checkOutput("rd_lat", 32'(lat), 3);
        checkOutput("rd_data", 32'(rdata), 9);
        checkOutput("rd_status", 32'(rstatus), ST_OK);
        checkOutput("rd_we_count", 32'(we_count), 0);

        // RESTOCK item 2 by 9 again saturates
        applyStimulus(OP_RESTOCK, 2'd2, 4'd9, lat, rdata, rstatus, we_count, ready_high);
        checkOutput("rs2_lat", 32'(lat), 4);
        checkOutput("rs2_data", 32'(rdata), 15);
        checkOutput("rs2_status", 32'(rstatus), ST_SAT);
        checkOutput("rs2_ram2", 32'(ram[2]), 15);

        // VEND item 2
        applyStimulus(OP_VEND, 2'd2, 4'd3, lat, rdata, rstatus, we_count, ready_high);
        checkOutput("v1_lat", 32'(lat), 4);
        checkOutput("v1_data", 32'(rdata), 14);
        checkOutput("v1_status", 32'(rstatus), ST_OK);
        checkOutput("v1_ram2", 32'(ram[2]), 14);

        // VEND empty item 1
        applyStimulus(OP_VEND, 2'd1, 4'd3, lat, rdata, rstatus, we_count, ready_high);
        checkOutput("v2_lat", 32'(lat), 3);
        checkOutput("v2_data", 32'(rdata), 0);
        checkOutput("v2_status", 32'(rstatus), ST_EMPTY);
        checkOutput("v2_we_count", 32'(we_count), 0);
        checkOutput("v2_ram1", 32'(ram[1]), 0);
        tick();
        checkOutput("hold_rspv", 32'(cmd_if.rsp_valid), 0);
        checkOutput("hold_status", 32'(cmd_if.rsp_status), ST_EMPTY);

        // RESTOCK item 3 to exactly the maximum is not clipped
        applyStimulus(OP_RESTOCK, 2'd3, 4'd15, lat, rdata, rstatus, we_count, ready_high);
        checkOutput("rs3_data", 32'(rdata), 15);
        checkOutput("rs3_status", 32'(rstatus), ST_OK);
        checkOutput("rs3_ram3", 32'(ram[3]), 15);
        tick();
        checkOutput("hold_data", 32'(cmd_if.rsp_data), 15);

        // Two READs of item 2 with req_valid held high
        cmd_if.req_valid = 1'b1;
        cmd_if.req_op    = OP_READ;
        cmd_if.req_item  = 2'd2;
        cmd_if.req_data  = 4'd0;
        accepts   = 0;
        pulses    = 0;
        ready_low = 0;
        acc_cycle[0] = -1;
        acc_cycle[1] = -1;
        for (int c = 0; c < 12; c++) begin
            if (cmd_if.req_ready && cmd_if.req_valid && accepts < 2) begin
                acc_cycle[accepts] = c;
                accepts++;
            end
            tick();
            if (accepts == 2) cmd_if.req_valid = 1'b0;
            if (cmd_if.rsp_valid) begin
                pulses++;
                checkOutput("q_data", 32'(cmd_if.rsp_data), 14);
            end
            if (!cmd_if.req_ready) ready_low++;
        end
        checkOutput("q_accepts", 32'(accepts), 2);
        checkOutput("q_gap", 32'(acc_cycle[1] - acc_cycle[0]), 4);
        checkOutput("q_pulses", 32'(pulses), 2);
        checkOutput("q_ready_low", 32'(ready_low), 6);

        // Reset during the WR cycle of a VEND on item 2
        guard = 0;
        while (!cmd_if.req_ready && guard < 20) begin
            tick();
            guard++;
        end
        cmd_if.req_valid = 1'b1;
        cmd_if.req_op    = OP_VEND;
        cmd_if.req_item  = 2'd2;
        tick();
        cmd_if.req_valid = 1'b0;
        tick();
        tick();
        checkOutput("wr_we", 32'(mem_we), 1);
        checkOutput("wr_wdata", 32'(mem_wdata), 13);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_we", 32'(mem_we), 0);
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (cmd_if.rsp_valid) pulses++;
        end
        checkOutput("abort_pulses", 32'(pulses), 0);
        checkOutput("abort_ram2", 32'(ram[2]), 14);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("abort_ready_low", 32'(cmd_if.req_ready), 0);
        tick();
        checkOutput("abort_ready", 32'(cmd_if.req_ready), 1);

        // Count on item 2 survives the aborted vend
        applyStimulus(OP_READ, 2'd2, 4'd0, lat, rdata, rstatus, we_count, ready_high);
        checkOutput("rd2_lat", 32'(lat), 3);
        checkOutput("rd2_data", 32'(rdata), 14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
